spf_line_ctrl: RTL and testbench

Sequencing controller for the two line-buffer FIFOs of the salt-and-pepper filter's 3×3 window generator. It counts incoming pixels into row/column positions, clears the line FIFOs between frames, and primes them to exactly one line of delay. In steady state it drives their write/read enables and flags each cycle on which a complete 3×3 window reaches the median stage. It sits between the pixel input stream and the window/tap datapath; the datapath carries the pixel data, this block carries only control.

---
 rtl/spf_pkg.sv | 21 ++
 rtl/spf_frame_pos.sv | 49 ++++
 rtl/spf_line_ctrl.sv | 175 +++++++++++++++++
 tb/tb_spf_line_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spf_pkg.sv
// Shared definitions for the salt-and-pepper filter line-buffer controller:
// image size defaults, FIFO depth helper and controller state encoding.
package spf_pkg;

    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_PRIME  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } spf_lc_state_t;

    // A 3x3 window needs one line of delay minus the three tap registers.
    function automatic int line_depth(input int w);
        return w - 3;
    endfunction

endpackage

// File: rtl/spf_frame_pos.sv
// Pixel position counter: column wraps at IMG_W-1 and advances the row;
// flags the last column, the last pixel of the frame and interior positions.
module spf_frame_pos
    import spf_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic                     clk,
    input  logic                     nres,
    input  logic                     clr,
    input  logic                     adv,
    output logic [$clog2(IMG_W)-1:0] col,
    output logic [$clog2(IMG_H)-1:0] row,
    output logic                     col_last,
    output logic                     last_pix,
    output logic                     interior
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO = CW'(2);
    localparam logic [RW-1:0] ROW_TWO = RW'(2);

    assign col_last = (col == COL_MAX);
    assign last_pix = col_last && (row == ROW_MAX);
    assign interior = (row >= ROW_TWO) && (col >= COL_TWO);

    // Column/row position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            if (col_last) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/spf_line_ctrl.sv
// Line-buffer sequencing controller for the 3x3 window generator.
// Optional framing check compiled in with macro SPF_SYNC_CHECK_EN.
module spf_line_ctrl
    import spf_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int LINE_DEPTH = line_depth(IMG_W)
) (
    input  logic                     clk,
    input  logic                     nres,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic                     in_eol,
    output logic [1:0]               lb_wr_en,
    output logic [1:0]               lb_rd_en,
    output logic                     lb_nres,
    output logic                     tap_shift,
    output logic                     win_valid,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     sync_err
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(LINE_DEPTH + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(LINE_DEPTH);

    spf_lc_state_t state_r;
    logic          done_cnt_r;
    logic [FW-1:0] fill0_r;
    logic [FW-1:0] fill1_r;
    logic          wr1_r;
    logic          s1_valid_r;
    logic          s1_last_r;
    logic [RW-1:0] s1_row_r;
    logic [CW-1:0] s1_col_r;
    logic [CW-1:0] col_s;
    logic [RW-1:0] row_s;
    logic          col_last_s;
    logic          last_pix_s;
    logic          interior_s;
    logic          start_s;
    logic          accept_s;
    logic          fault_s;
    logic          rd0_s;

`ifdef SPF_SYNC_CHECK_EN
    assign start_s = (state_r == ST_IDLE) && in_valid && in_sof;
    // Framing fault: restart mid-frame or line length disagreeing with in_eol.
    assign fault_s = accept_s && ((in_sof && !start_s) || (in_eol != col_last_s));
`else
    logic sync_unused_s;
    assign start_s       = (state_r == ST_IDLE) && in_valid;
    assign fault_s       = 1'b0;
    assign sync_unused_s = in_sof ^ in_eol;
`endif

    assign accept_s  = start_s || (in_valid && ((state_r == ST_PRIME) || (state_r == ST_STREAM)));
    assign rd0_s     = accept_s && (fill0_r == FILL_FULL);
    assign lb_wr_en  = {wr1_r, accept_s};
    assign lb_rd_en  = {wr1_r && (fill1_r == FILL_FULL), rd0_s};
    assign tap_shift = accept_s;
    assign lb_nres   = (state_r != ST_CLEAR);
    assign busy      = start_s || (state_r == ST_PRIME) || (state_r == ST_STREAM) || (state_r == ST_DONE);

    spf_frame_pos #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_pos (
        .clk      (clk),
        .nres     (nres),
        .clr      (state_r == ST_CLEAR),
        .adv      (accept_s),
        .col      (col_s),
        .row      (row_s),
        .col_last (col_last_s),
        .last_pix (last_pix_s),
        .interior (interior_s)
    );

    // Frame sequencing FSM.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state_r    <= ST_CLEAR;
            done_cnt_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: state_r <= ST_IDLE;
                ST_IDLE: begin
                    if (fault_s)      state_r <= ST_CLEAR;
                    else if (start_s) state_r <= ST_PRIME;
                    else              state_r <= ST_IDLE;
                end
                ST_PRIME: begin
                    if (fault_s)                                        state_r <= ST_CLEAR;
                    else if (accept_s && col_last_s && row_s == RW'(1)) state_r <= ST_STREAM;
                    else                                                state_r <= ST_PRIME;
                end
                ST_STREAM: begin
                    if (fault_s) begin
                        state_r <= ST_CLEAR;
                    end else if (accept_s && last_pix_s) begin
                        state_r    <= ST_DONE;
                        done_cnt_r <= 1'b0;
                    end else begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_DONE: begin
                    if (done_cnt_r) state_r <= ST_CLEAR;
                    else            done_cnt_r <= 1'b1;
                end
                default: state_r <= ST_CLEAR;
            endcase
        end
    end

    // FIFO occupancy tracking; FIFO 1 is written with FIFO 0's registered read data.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            fill0_r <= '0;
            fill1_r <= '0;
            wr1_r   <= 1'b0;
        end else begin
            wr1_r <= rd0_s;
            if (state_r == ST_CLEAR) begin
                fill0_r <= '0;
                fill1_r <= '0;
            end else begin
                if (accept_s && (fill0_r != FILL_FULL)) fill0_r <= fill0_r + FW'(1);
                if (wr1_r && (fill1_r != FILL_FULL))    fill1_r <= fill1_r + FW'(1);
            end
        end
    end

    // Two-stage window report pipeline; a framing fault flushes it.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_row_r   <= '0;
            s1_col_r   <= '0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else if (fault_s) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            s1_valid_r <= accept_s && interior_s;
            s1_last_r  <= accept_s && last_pix_s;
            s1_row_r   <= row_s - RW'(1);
            s1_col_r   <= col_s - CW'(1);
            win_valid  <= s1_valid_r;
            win_row    <= s1_row_r;
            win_col    <= s1_col_r;
            frame_done <= s1_last_r;
        end
    end

`ifdef SPF_SYNC_CHECK_EN
    // Framing error pulse, one cycle after the offending pixel.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) sync_err <= 1'b0;
        else       sync_err <= fault_s;
    end
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_spf_line_ctrl.sv
// Randomised bench for spf_line_ctrl (8x4 image) against a pixel-count based
// reference model; honours SPF_SYNC_CHECK_EN when the bundle is built with it.
module tb_spf_line_ctrl;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int LD   = W - 3;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 2) * (H - 2);
    localparam int NCYC = 3000;

    logic                     clk = 1'b0;
    logic                     nres = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_sof = 1'b0;
    logic                     in_eol = 1'b0;
    logic [1:0]               lb_wr_en;
    logic [1:0]               lb_rd_en;
    logic                     lb_nres;
    logic                     tap_shift;
    logic                     win_valid;
    logic [$clog2(H)-1:0]     win_row;
    logic [$clog2(W)-1:0]     win_col;
    logic                     frame_done;
    logic                     busy;
    logic                     sync_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spf_line_ctrl #(.IMG_W(W), .IMG_H(H), .LINE_DEPTH(LD)) dut (
        .clk        (clk),
        .nres       (nres),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_eol     (in_eol),
        .lb_wr_en   (lb_wr_en),
        .lb_rd_en   (lb_rd_en),
        .lb_nres    (lb_nres),
        .tap_shift  (tap_shift),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done),
        .busy       (busy),
        .sync_err   (sync_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 clear, 1 idle, 2 in frame, 3/4 the two done cycles.
    typedef struct { int due; int r; int c; } win_t;
    win_t wq[$];
    int   ph, p, nw1, cyc, fd_due, err_due, win_obs, frames_done;
    bit   prev_rd0;

    // Stimulus state
    int   f, sp, gap, mode, bad_eol_at;
    bit   nosof, tg, did_rst;

    task automatic model_reset();
        ph = 0; p = 0; nw1 = 0; prev_rd0 = 1'b0;
        wq.delete(); fd_due = -1; err_due = -1; win_obs = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_lb_nres"}, lb_nres, 0);
        chk({tag, "_wr"}, lb_wr_en, 0);
        chk({tag, "_rd"}, lb_rd_en, 0);
        chk({tag, "_tap"}, tap_shift, 0);
        chk({tag, "_win"}, win_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fdone"}, frame_done, 0);
        chk({tag, "_serr"}, sync_err, 0);
    endtask

    task automatic next_frame();
        f++;
        sp = 0; tg = 1'b0;
        gap = 3 + $urandom_range(0, 3);
        nosof = 1'b0; bad_eol_at = -1;
        if (f == 0)      mode = 0;
        else if (f == 1) mode = 1;
        else if (f == 2) mode = 2;
        else if (f == 3) begin
            mode = 0;
`ifdef SPF_SYNC_CHECK_EN
            bad_eol_at = W + 3;
`else
            nosof = 1'b1;
`endif
        end
        else if (f == 4) mode = 0;
        else             mode = $urandom_range(0, 2);
    endtask

    task automatic drive();
        bit v;
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
        if (gap > 0) begin
            gap--;
        end else begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = ~tg; tg = ~tg; end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            if (v) begin
                in_valid = 1'b1;
                in_sof   = (sp == 0) && !nosof;
                in_eol   = ((sp % W) == W - 1) || (sp == bad_eol_at);
                sp++;
                if (sp == NPIX || sp - 1 == bad_eol_at) next_frame();
            end
        end
    endtask

    task automatic eval_cycle();
        bit start, acc, rd0, fault, ev;
        int r, c;
        start = (ph == 1) && in_valid;
`ifdef SPF_SYNC_CHECK_EN
        start = start && in_sof;
`endif
        acc = in_valid && (start || ph == 2);
        rd0 = acc && (p >= LD);
        chk("busy", busy, start || ph >= 2);
        chk("lb_nres", lb_nres, ph != 0);
        chk("wr0", lb_wr_en[0], acc);
        chk("tap_shift", tap_shift, acc);
        chk("rd0", lb_rd_en[0], rd0);
        chk("wr1", lb_wr_en[1], prev_rd0);
        chk("rd1", lb_rd_en[1], prev_rd0 && nw1 >= LD);
        if (win_valid) win_obs++;
        ev = (wq.size() > 0) && (wq[0].due == cyc);
        chk("win_valid", win_valid, ev);
        if (ev) begin
            chk("win_row", win_row, wq[0].r);
            chk("win_col", win_col, wq[0].c);
            void'(wq.pop_front());
        end
        chk("frame_done", frame_done, fd_due == cyc);
        if (fd_due == cyc) begin
            chk("win_count", win_obs, NWIN);
            win_obs = 0;
            frames_done++;
        end
        chk("sync_err", sync_err, err_due == cyc);

        fault = 1'b0;
`ifdef SPF_SYNC_CHECK_EN
        if (acc) fault = (in_sof && !start) || (in_eol != ((p % W) == W - 1));
`endif
        if (ph == 0)       nw1 = 0;
        else if (prev_rd0) nw1++;
        prev_rd0 = rd0;
        if (acc) begin
            r = p / W;
            c = p % W;
            if (r >= 2 && c >= 2) wq.push_back('{due: cyc + 2, r: r - 1, c: c - 1});
            p++;
        end
        if (fault) begin
            wq.delete(); fd_due = -1; err_due = cyc + 1; ph = 0; win_obs = 0;
        end else begin
            case (ph)
                0:       begin ph = 1; p = 0; end
                1:       if (start) ph = 2;
                2:       if (p == NPIX) begin ph = 3; fd_due = cyc + 2; end
                3:       ph = 4;
                default: ph = 0;
            endcase
        end
        cyc++;
    endtask

    task automatic do_reset_mid();
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
        nres = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        check_reset_outputs("midrst_hold");
        @(posedge clk); #1;
        nres = 1'b1;
        model_reset();
        f = 5;
        next_frame();
        did_rst = 1'b1;
    endtask

    initial begin
        cyc = 0; frames_done = 0; did_rst = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        nres = 1'b1;
        f = -1;
        next_frame();
        for (int n = 0; n < NCYC; n++) begin
            if (f == 5 && sp == 12 && !did_rst) do_reset_mid();
            drive();
            @(negedge clk);
            eval_cycle();
            @(posedge clk); #1;
        end
        chk("frames_min", frames_done >= 20, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
